// File: rtl/secuenciador_pkg.sv
// Shared types and sizing helpers for the reduction sequencer.
package secuenciador_pkg;

  typedef enum logic [2:0] {
    S_ESPERA    = 3'd0,
    S_CARGA     = 3'd1,
    S_CALCULO   = 3'd2,
    S_ESCRITURA = 3'd3,
    S_FIN       = 3'd4
  } estado_t;

  localparam int LAT_CALCULO_DEF = 2;

  // The compute counter must be able to hold LAT_CALCULO itself.
  function automatic int ancho_contador(input int lat);
    return $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/contador_coordenadas.sv
// Output-image walker: holds the coordinates of the current group, advances
// them row-major in steps of N_CARRILES and flags the final group.
module contador_coordenadas #(
  parameter int N_CARRILES  = 4,
  parameter int ANCHO_COORD = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   limpiar,
  input  logic                   avanzar_grupo,
  input  logic [ANCHO_COORD-1:0] ancho,
  input  logic [ANCHO_COORD-1:0] alto,
  output logic [ANCHO_COORD-1:0] x,
  output logic [ANCHO_COORD-1:0] y,
  output logic                   ultimo_grupo
);

  localparam logic [ANCHO_COORD:0]   PASO_X = (ANCHO_COORD+1)'(N_CARRILES);
  localparam logic [ANCHO_COORD-1:0] UNO    = ANCHO_COORD'(1);

  logic [ANCHO_COORD:0] x_siguiente;
  logic                 fila_cierra;

  // One extra bit keeps x+N from wrapping near the top of the coordinate range.
  assign x_siguiente  = {1'b0, x} + PASO_X;
  assign fila_cierra  = x_siguiente >= {1'b0, ancho};
  assign ultimo_grupo = fila_cierra && (y == alto - UNO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (limpiar) begin
      x <= '0;
      y <= '0;
    end else if (avanzar_grupo) begin
      if (fila_cierra) begin
        x <= '0;
        y <= y + UNO;
      end else begin
        x <= x_siguiente[ANCHO_COORD-1:0];
      end
    end
  end

endmodule

// File: rtl/secuenciador_reduccion.sv
// Group sequencer for the parallel bilinear downscaler: load/compute/write per
// group of lanes. Define SECUENCIADOR_PERF_EN to add the ciclos_oper busy counter.
module secuenciador_reduccion
  import secuenciador_pkg::*;
#(
  parameter int N_CARRILES  = 4,
  parameter int ANCHO_COORD = 10,
  parameter int LAT_CALCULO = LAT_CALCULO_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   iniciar,
  input  logic                   abortar,
  input  logic                   modo_paso,
  input  logic                   paso,
  input  logic [ANCHO_COORD-1:0] ancho_sal,
  input  logic [ANCHO_COORD-1:0] alto_sal,
  input  logic                   mem_listo,
  output logic                   cargar,
  output logic                   calcular,
  output logic                   escribir,
  output logic [ANCHO_COORD-1:0] x_sal,
  output logic [ANCHO_COORD-1:0] y_sal,
  output logic [N_CARRILES-1:0]  carriles_validos,
  output logic                   ocupado,
  output logic                   listo,
  output logic                   fin_imagen
`ifdef SECUENCIADOR_PERF_EN
  ,
  output logic [31:0]            ciclos_oper
`endif
);

  localparam int ANCHO_CNT = ancho_contador(LAT_CALCULO);
  localparam logic [ANCHO_CNT-1:0] CNT_ULTIMO = ANCHO_CNT'(LAT_CALCULO - 1);

  estado_t                estado;
  logic [ANCHO_CNT-1:0]   cnt_calculo;
  logic [ANCHO_COORD-1:0] ancho_lat;
  logic [ANCHO_COORD-1:0] alto_lat;
  logic                   avanzar;
  logic                   arranque;
  logic                   ultimo_grupo;
  logic                   avanzar_grupo;

  assign avanzar  = modo_paso ? paso : 1'b1;
  assign arranque = avanzar && !abortar && iniciar &&
                    (ancho_sal != '0) && (alto_sal != '0) &&
                    ((estado == S_ESPERA) || (estado == S_FIN));
  assign avanzar_grupo = (estado == S_ESCRITURA) && avanzar && !abortar && !ultimo_grupo;

  contador_coordenadas #(
    .N_CARRILES (N_CARRILES),
    .ANCHO_COORD(ANCHO_COORD)
  ) u_coordenadas (
    .clk          (clk),
    .rst_n        (rst_n),
    .limpiar      (abortar || arranque),
    .avanzar_grupo(avanzar_grupo),
    .ancho        (ancho_lat),
    .alto         (alto_lat),
    .x            (x_sal),
    .y            (y_sal),
    .ultimo_grupo (ultimo_grupo)
  );

  // abortar overrides everything else, including a pending step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado      <= S_ESPERA;
      cnt_calculo <= '0;
      ancho_lat   <= '0;
      alto_lat    <= '0;
    end else if (abortar) begin
      estado      <= S_ESPERA;
      cnt_calculo <= '0;
    end else if (avanzar) begin
      if (arranque) begin
        ancho_lat <= ancho_sal;
        alto_lat  <= alto_sal;
      end
      case (estado)
        S_ESPERA:    if (arranque) estado <= S_CARGA;
        S_CARGA: begin
          if (mem_listo) begin
            estado      <= S_CALCULO;
            cnt_calculo <= '0;
          end
        end
        S_CALCULO: begin
          if (cnt_calculo == CNT_ULTIMO) estado <= S_ESCRITURA;
          else cnt_calculo <= cnt_calculo + ANCHO_CNT'(1);
        end
        S_ESCRITURA: estado <= ultimo_grupo ? S_FIN : S_CARGA;
        S_FIN:       estado <= arranque ? S_CARGA : S_ESPERA;
        default:     estado <= S_ESPERA;
      endcase
    end
  end

  assign ocupado    = (estado == S_CARGA) || (estado == S_CALCULO) || (estado == S_ESCRITURA);
  assign listo      = (estado == S_ESPERA) || (estado == S_FIN);
  assign cargar     = (estado == S_CARGA) && avanzar && mem_listo;
  assign calcular   = (estado == S_CALCULO) && avanzar;
  assign escribir   = (estado == S_ESCRITURA) && avanzar;
  assign fin_imagen = (estado == S_FIN) && avanzar;

  always_comb begin
    carriles_validos = '0;
    for (int i = 0; i < N_CARRILES; i++) begin
      carriles_validos[i] = ocupado &&
        (({1'b0, x_sal} + (ANCHO_COORD+1)'(i)) < {1'b0, ancho_lat});
    end
  end

`ifdef SECUENCIADOR_PERF_EN
  // Busy-cycle counter, stalls included; saturates rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ciclos_oper <= '0;
    end else if (arranque) begin
      ciclos_oper <= '0;
    end else if (ocupado && (ciclos_oper != 32'hFFFF_FFFF)) begin
      ciclos_oper <= ciclos_oper + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_secuenciador_reduccion.sv
// Self-checking bench for secuenciador_reduccion: per-cycle model compare plus
// directed scenarios with hand-computed expectations.
module tb_secuenciador_reduccion;

  localparam int N   = 4;
  localparam int AC  = 10;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          iniciar = 1'b0;
  logic          abortar = 1'b0;
  logic          modo_paso = 1'b0;
  logic          paso = 1'b0;
  logic          mem_listo = 1'b1;
  logic [AC-1:0] ancho_sal = '0;
  logic [AC-1:0] alto_sal = '0;
  logic          cargar, calcular, escribir, ocupado, listo, fin_imagen;
  logic [AC-1:0] x_sal, y_sal;
  logic [N-1:0]  carriles_validos;
`ifdef SECUENCIADOR_PERF_EN
  logic [31:0]   ciclos_oper;
`endif

  secuenciador_reduccion #(
    .N_CARRILES (N),
    .ANCHO_COORD(AC),
    .LAT_CALCULO(LAT)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .iniciar         (iniciar),
    .abortar         (abortar),
    .modo_paso       (modo_paso),
    .paso            (paso),
    .ancho_sal       (ancho_sal),
    .alto_sal        (alto_sal),
    .mem_listo       (mem_listo),
    .cargar          (cargar),
    .calcular        (calcular),
    .escribir        (escribir),
    .x_sal           (x_sal),
    .y_sal           (y_sal),
    .carriles_validos(carriles_validos),
    .ocupado         (ocupado),
    .listo           (listo),
    .fin_imagen      (fin_imagen)
`ifdef SECUENCIADOR_PERF_EN
    ,
    .ciclos_oper     (ciclos_oper)
`endif
  );

  always #5 clk = ~clk;

  int errores = 0;
  int checks  = 0;
  bit chk_en  = 1'b0;

  task automatic checkOutput(input string nombre, input logic [63:0] actual,
                             input logic [63:0] esperado);
    checks++;
    if (actual !== esperado) begin
      errores++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", nombre, actual, esperado, $time);
    end
  endtask

  task automatic applyStimulus(input logic ini, input int w, input int h, input logic mp,
                               input logic p, input logic ab, input logic ml);
    iniciar   = ini;
    ancho_sal = AC'(w);
    alto_sal  = AC'(h);
    modo_paso = mp;
    paso      = p;
    abortar   = ab;
    mem_listo = ml;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: m_modo 0 idle, 1 working on a group, 2 image finished.
  // m_fase is the step inside a group: 0 load, 1..LAT compute, LAT+1 write.
  int     m_modo = 0, m_fase = 0, m_x = 0, m_y = 0, m_w = 0, m_h = 0;
  longint m_perf = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_modo = 0; m_fase = 0; m_x = 0; m_y = 0; m_w = 0; m_h = 0; m_perf = 0;
    end else begin
      if (m_modo == 1) m_perf++;
      if (abortar) begin
        m_modo = 0; m_x = 0; m_y = 0;
      end else if (!modo_paso || paso) begin
        if (m_modo == 0 || m_modo == 2) begin
          if (iniciar && ancho_sal != 0 && alto_sal != 0) begin
            m_w = int'(ancho_sal); m_h = int'(alto_sal);
            m_x = 0; m_y = 0; m_modo = 1; m_fase = 0; m_perf = 0;
          end else begin
            m_modo = 0;
          end
        end else if (m_fase == 0) begin
          if (mem_listo) m_fase = 1;
        end else if (m_fase <= LAT) begin
          m_fase++;
        end else if (m_y == m_h - 1 && m_x + N >= m_w) begin
          m_modo = 2;
        end else begin
          m_fase = 0;
          if (m_x + N < m_w) m_x += N;
          else begin m_x = 0; m_y++; end
        end
      end
    end
  end

  function automatic logic [29:0] esperado();
    logic av, oc;
    logic [N-1:0] m;
    av = modo_paso ? paso : 1'b1;
    oc = (m_modo == 1);
    for (int i = 0; i < N; i++) m[i] = oc && (m_x + i < m_w);
    return {oc && m_fase == 0 && av && mem_listo,
            oc && m_fase >= 1 && m_fase <= LAT && av,
            oc && m_fase == LAT + 1 && av,
            (m_modo == 2) && av, oc, !oc, m, AC'(m_x), AC'(m_y)};
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("ciclo", {cargar, calcular, escribir, fin_imagen, ocupado, listo,
                            carriles_validos, x_sal, y_sal}, esperado());
`ifdef SECUENCIADOR_PERF_EN
      checkOutput("ciclos_oper", ciclos_oper, m_perf);
`endif
    end
  end

  int q_x[$];
  int q_y[$];
  logic [N-1:0] q_m[$];
  int n_esc;

  // Free-run an already started image; mem_listo returns high after 'stall' edges.
  task automatic runImage(input int stall, output int ciclos);
    ciclos = 0; n_esc = 0;
    q_x.delete(); q_y.delete(); q_m.delete();
    while (ciclos < 200) begin
      @(negedge clk);
      if (cargar) begin
        q_x.push_back(int'(x_sal)); q_y.push_back(int'(y_sal)); q_m.push_back(carriles_validos);
      end
      if (escribir) n_esc++;
      if (fin_imagen) break;
      @(posedge clk);
      ciclos++;
      #1;
      if (ciclos == stall) mem_listo = 1'b1;
    end
  endtask

  int ciclos, strobes, sin_paso;

  initial begin
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    checkOutput("reset_estado", {listo, ocupado, cargar, escribir, fin_imagen, carriles_validos},
                {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000});
    checkOutput("reset_xy", {x_sal, y_sal}, 20'd0);

    // 8x2 free run: four 4-cycle groups, fin 16 cycles after start
    tick(); applyStimulus(1, 8, 2, 0, 0, 0, 1);
    tick(); applyStimulus(0, 8, 2, 0, 0, 0, 1);
    runImage(0, ciclos);
    checkOutput("t1_ciclos_fin", ciclos, 16);
    checkOutput("t1_n_grupos", q_x.size(), 4);
    checkOutput("t1_n_escrituras", n_esc, 4);
    checkOutput("t1_g0", {q_x[0][15:0], q_y[0][15:0]}, {16'd0, 16'd0});
    checkOutput("t1_g1", {q_x[1][15:0], q_y[1][15:0]}, {16'd4, 16'd0});
    checkOutput("t1_g2", {q_x[2][15:0], q_y[2][15:0]}, {16'd0, 16'd1});
    checkOutput("t1_g3", {q_x[3][15:0], q_y[3][15:0]}, {16'd4, 16'd1});

    // 6x1: partial second group
    tick(); applyStimulus(1, 6, 1, 0, 0, 0, 1);
    tick(); applyStimulus(0, 6, 1, 0, 0, 0, 1);
    runImage(0, ciclos);
    checkOutput("t2_ciclos_fin", ciclos, 8);
    checkOutput("t2_mask0", q_m[0], 4'b1111);
    checkOutput("t2_x1", q_x[1], 4);
    checkOutput("t2_mask1", q_m[1], 4'b0011);

    // 8x2 with mem_listo low for the first 3 load cycles
    tick(); applyStimulus(1, 8, 2, 0, 0, 0, 0);
    tick(); applyStimulus(0, 8, 2, 0, 0, 0, 0);
    runImage(3, ciclos);
    checkOutput("t3_ciclos_fin", ciclos, 19);
    checkOutput("t3_n_cargas", q_x.size(), 4);

    // single step: one paso every 5 cycles, 17 strobes total for 8x2
    tick(); applyStimulus(1, 8, 2, 1, 1, 0, 1);
    tick(); applyStimulus(0, 8, 2, 1, 0, 0, 1);
    strobes = 0; sin_paso = 0;
    for (int k = 0; k < 100; k++) begin
      paso = (k % 5 == 4);
      @(negedge clk);
      if (cargar || calcular || escribir || fin_imagen) begin
        strobes++;
        if (!paso) sin_paso++;
      end
      tick();
    end
    checkOutput("t4_strobes", strobes, 17);
    checkOutput("t4_sin_paso", sin_paso, 0);
    checkOutput("t4_listo", listo, 1'b1);

    // abort during compute of group 2, same cycle as paso
    applyStimulus(1, 8, 2, 1, 1, 0, 1);
    tick();
    for (int p = 0; p < 5; p++) begin
      applyStimulus(0, 8, 2, 1, 0, 0, 1); tick();
      applyStimulus(0, 8, 2, 1, 1, 0, 1); tick();
    end
    applyStimulus(0, 8, 2, 1, 0, 0, 1);
    @(negedge clk);
    checkOutput("t5_antes_x", x_sal, 4);
    tick(); applyStimulus(0, 8, 2, 1, 1, 1, 1);
    tick(); applyStimulus(0, 8, 2, 1, 1, 0, 1);
    @(negedge clk);
    checkOutput("t5_tras_abortar", {listo, ocupado, escribir, fin_imagen, x_sal, y_sal},
                {1'b1, 1'b0, 1'b0, 1'b0, 20'd0});

    // iniciar held through FIN chains; zero width ignored
    tick(); applyStimulus(1, 4, 1, 0, 0, 0, 1);
    tick();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (fin_imagen) break;
      tick();
    end
    checkOutput("t6_fin", fin_imagen, 1'b1);
    tick();
    @(negedge clk);
    checkOutput("t6_encadenado", {ocupado, cargar, x_sal, y_sal}, {1'b1, 1'b1, 20'd0});
    tick(); applyStimulus(1, 4, 1, 0, 0, 1, 1);
    tick(); applyStimulus(1, 0, 1, 0, 0, 0, 1);
    repeat (3) tick();
    @(negedge clk);
    checkOutput("t6_dim_cero", {listo, ocupado}, 2'b10);

    // asynchronous reset mid-image
    tick(); applyStimulus(1, 8, 2, 0, 0, 0, 1);
    tick(); applyStimulus(0, 8, 2, 0, 0, 0, 1);
    repeat (6) tick();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset_async", {listo, ocupado, cargar, calcular, escribir, carriles_validos, x_sal, y_sal},
                {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 20'd0});
    tick();
    rst_n = 1'b1;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errores, checks);
    $finish;
  end

endmodule
